// File: rtl/ssd_pkg.sv
// Shared constants for the score seven-segment driver: segment codes,
// anode-off pattern, clamp limit and the conversion FSM encoding.
package ssd_pkg;

  // Active-low segment codes, bit 6 = Ca ... bit 0 = Cg.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All digit enables off (active-low).
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Largest value the four digits can show.
  localparam int unsigned SCORE_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // BCD nibble to active-low segment pattern; non-decimal codes go blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result committed
// to digits_o only once the full conversion has finished.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [15:0]        digits_o,
  output logic               busy_o
);

  localparam int SR_W = 16 + SCORE_W;
  localparam int IT_W = $clog2(SCORE_W + 1);

  conv_state_e        state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [SCORE_W-1:0] last_q, last_d;
  logic [IT_W-1:0]    iter_q, iter_d;
  logic [15:0]        digits_q, digits_d;

  logic [SCORE_W-1:0] score_c;
  logic [SR_W-1:0]    adj;

  // Saturate so the value always fits in four decimal digits.
  assign score_c = (32'(score_i) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : score_i;

  // Next-state logic: nibble correction, shift, and result commit.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    last_d   = last_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    adj      = sr_q;
    for (int k = 0; k < 4; k++) begin
      if (sr_q[SCORE_W + 4*k +: 4] >= 4'd5) begin
        adj[SCORE_W + 4*k +: 4] = sr_q[SCORE_W + 4*k +: 4] + 4'd3;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (score_c != last_q) begin
          sr_d    = {16'b0, score_c};
          last_d  = score_c;
          iter_d  = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_d   = {adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + 1'b1;
        if (iter_q == IT_W'(SCORE_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        digits_d = sr_q[SR_W-1:SCORE_W];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      last_q   <= '0;
      iter_q   <= '0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      last_q   <= last_d;
      iter_q   <= iter_d;
      digits_q <= digits_d;
    end
  end

  assign digits_o = digits_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: rtl/score_ssd_driver.sv
// Score display driver: converts the binary score to BCD and scans the four
// digits with leading-zero blanking onto registered anode/segment outputs.
module score_ssd_driver
  import ssd_pkg::*;
#(
  parameter int SCORE_W      = 14,
  parameter int REFRESH_BITS = 18
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [SCORE_W-1:0] score,
  output logic [3:0]         anode,
  output logic [6:0]         ssdOut,
  output logic               busy
);

  logic [15:0]             digits;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              ssd_q, ssd_d;
  logic [1:0]              sel;
  logic [3:0]              nib;
  logic                    blank;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_conv (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .score_i  (score),
    .digits_o (digits),
    .busy_o   (busy)
  );

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];
  assign nib = digits[{sel, 2'b00} +: 4];

  // Digit select, blanking of leading zeros and segment lookup.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    blank     = 1'b0;
    case (sel)
      2'd1:    blank = (digits[15:4]  == 12'd0);
      2'd2:    blank = (digits[15:8]  == 8'd0);
      2'd3:    blank = (digits[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    if (blank) begin
      anode_d = ANODE_OFF;
      ssd_d   = SEG_BLANK;
    end else begin
      anode_d = ~(4'b0001 << sel);
      ssd_d   = seg_encode(nib);
    end
  end

  // Free-running refresh counter and registered display outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      refresh_q <= '0;
      anode_q   <= ANODE_OFF;
      ssd_q     <= SEG_BLANK;
    end else begin
      refresh_q <= refresh_d;
      anode_q   <= anode_d;
      ssd_q     <= ssd_d;
    end
  end

  assign anode  = anode_q;
  assign ssdOut = ssd_q;

endmodule
